// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter: bus widths, counter width and FSM states.
package dmem_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundles the CPU port, device port, RAM port and debug observables of the data-RAM arbiter.
interface dmem_arbiter_if import dmem_pkg::*; #(
  parameter int AW = dmem_pkg::ADDR_W,
  parameter int DW = dmem_pkg::DATA_W
) ();
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          dev_req;
  logic          dev_we;
  logic [AW-1:0] dev_addr;
  logic [DW-1:0] dev_wdata;
  logic          dev_gnt;
  logic [DW-1:0] dev_rdata;
  logic          dev_rvalid;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [CNT_W-1:0] starve_cnt;
  logic             rd_owner_dev;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dev_req, dev_we, dev_addr, dev_wdata,
    output dev_gnt, dev_rdata, dev_rvalid,
    output ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output starve_cnt, rd_owner_dev
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dev_req, dev_we, dev_addr, dev_wdata,
    input  dev_gnt, dev_rdata, dev_rvalid,
    input  ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  starve_cnt, rd_owner_dev
  );
endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating count of consecutive denied device cycles; flags when the next value reaches the limit.
module starve_counter import dmem_pkg::*; #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             limit_hit
);
  logic [CNT_W-1:0] cnt_next;

  // next count: clear wins, increment saturates at all-ones
  always_comb begin
    cnt_next = cnt;
    if (clr) begin
      cnt_next = 8'd0;
    end else if (inc && (cnt != 8'hFF)) begin
      cnt_next = cnt + 8'd1;
    end else begin
      cnt_next = cnt;
    end
  end

  assign limit_hit = (cnt_next >= CNT_W'(STARVE_LIMIT));

  // counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt_next;
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Fixed-priority CPU / device arbiter for the single-port data RAM, with a one-cycle
// forced device grant after STARVE_LIMIT consecutive denials.
module dmem_arbiter import dmem_pkg::*; #(
  parameter int ADDR_W       = dmem_pkg::ADDR_W,
  parameter int DATA_W       = dmem_pkg::DATA_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clock,
  input  logic          reset,
  dmem_arbiter_if.master bus
);
  arb_state_t        state;
  arb_state_t        state_next;
  logic              cpu_gnt;
  logic              dev_gnt;
  logic              cpu_stall;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              limit_hit;
  logic [CNT_W-1:0]  starve_cnt;
  logic              dev_rvalid;
  logic              rd_owner_dev;

  // grant decision; all grants are suppressed while reset is asserted
  always_comb begin
    cpu_gnt   = 1'b0;
    dev_gnt   = 1'b0;
    cpu_stall = 1'b0;
    if (reset) begin
      dev_gnt = 1'b0;
    end else if ((state == FORCE) && bus.dev_req) begin
      dev_gnt   = 1'b1;
      cpu_stall = bus.cpu_req;
    end else if (bus.cpu_req) begin
      cpu_gnt = 1'b1;
    end else if (bus.dev_req) begin
      dev_gnt = 1'b1;
    end else begin
      cpu_gnt = 1'b0;
    end
  end

  // RAM mux; with no grant the CPU inputs flow through with the write disabled
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = bus.cpu_addr;
    ram_wdata = bus.cpu_wdata;
    if (dev_gnt) begin
      ram_we    = bus.dev_we;
      ram_addr  = bus.dev_addr;
      ram_wdata = bus.dev_wdata;
    end else if (cpu_gnt) begin
      ram_we = bus.cpu_we;
    end else begin
      ram_we = 1'b0;
    end
  end

  // a forced cycle always hands the following cycle back to the CPU
  always_comb begin
    state_next = state;
    case (state)
      NORMAL:  state_next = limit_hit ? FORCE : NORMAL;
      FORCE:   state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
  end

  starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_cnt (
    .clock     (clock),
    .reset     (reset),
    .inc       (bus.dev_req && !dev_gnt),
    .clr       (dev_gnt || !bus.dev_req),
    .cnt       (starve_cnt),
    .limit_hit (limit_hit)
  );

  // state, read-valid pulse and debug read-owner registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= NORMAL;
      dev_rvalid   <= 1'b0;
      rd_owner_dev <= 1'b0;
    end else begin
      state      <= state_next;
      dev_rvalid <= dev_gnt && !bus.dev_we;
      if (dev_gnt && !bus.dev_we) begin
        rd_owner_dev <= 1'b1;
      end else if (cpu_gnt && !bus.cpu_we) begin
        rd_owner_dev <= 1'b0;
      end else begin
        rd_owner_dev <= rd_owner_dev;
      end
    end
  end

  assign bus.cpu_rdata    = bus.ram_rdata;
  assign bus.cpu_stall    = cpu_stall;
  assign bus.dev_gnt      = dev_gnt;
  assign bus.dev_rdata    = bus.ram_rdata;
  assign bus.dev_rvalid   = dev_rvalid;
  assign bus.ram_we       = ram_we;
  assign bus.ram_addr     = ram_addr;
  assign bus.ram_wdata    = ram_wdata;
  assign bus.starve_cnt   = starve_cnt;
  assign bus.rd_owner_dev = rd_owner_dev;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed cycles push expectations, a negedge monitor checks them.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam logic [31:0] DB  = 32'hDEADBEEF;
  localparam logic [31:0] H12 = 32'h12345678;
  localparam logic [31:0] CF  = 32'hCAFE0030;

  typedef struct packed {
    logic        gnt;
    logic        stall;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wd;
    logic        rvalid;
    logic [7:0]  cnt;
    logic        chk_rd;
    logic [31:0] rd;
    logic        force_st;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem [0:4095];
  exp_t        exp_q [$];
  logic [31:0] rd_q [$];
  exp_t        e;
  int          n_chk = 0;
  int          n_fail = 0;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.STARVE_LIMIT(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dev_gnt",    32'(bus.dev_gnt),    32'(e.gnt));
      chk("cpu_stall",  32'(bus.cpu_stall),  32'(e.stall));
      chk("ram_we",     32'(bus.ram_we),     32'(e.we));
      chk("ram_addr",   32'(bus.ram_addr),   32'(e.addr));
      chk("ram_wdata",  bus.ram_wdata,       e.wd);
      chk("dev_rvalid", 32'(bus.dev_rvalid), 32'(e.rvalid));
      chk("starve_cnt", 32'(bus.starve_cnt), 32'(e.cnt));
      chk("force_state", 32'(dut.state == FORCE), 32'(e.force_st));
      if (e.chk_rd) chk("cpu_rdata", bus.cpu_rdata, e.rd);
    end
    if (bus.dev_rvalid) begin
      if (rd_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL dev_rvalid_unexpected: got 1 expected no pending read at %0t", $time);
      end else begin
        chk("dev_rdata", bus.dev_rdata, rd_q.pop_front());
      end
    end
  end

  task automatic step(
    input logic rst,
    input logic c_req, input logic c_we, input logic [11:0] c_addr, input logic [31:0] c_wd,
    input logic d_req, input logic d_we, input logic [11:0] d_addr, input logic [31:0] d_wd,
    input logic e_gnt, input logic e_stall, input logic e_we, input logic [11:0] e_addr,
    input logic [31:0] e_wd, input logic e_rv, input logic [7:0] e_cnt,
    input logic e_chk, input logic [31:0] e_rd, input logic e_force);
    exp_t x;
    @(posedge clock);
    #1;
    reset         = rst;
    bus.cpu_req   = c_req;
    bus.cpu_we    = c_we;
    bus.cpu_addr  = c_addr;
    bus.cpu_wdata = c_wd;
    bus.dev_req   = d_req;
    bus.dev_we    = d_we;
    bus.dev_addr  = d_addr;
    bus.dev_wdata = d_wd;
    x.gnt = e_gnt; x.stall = e_stall; x.we = e_we; x.addr = e_addr; x.wd = e_wd;
    x.rvalid = e_rv; x.cnt = e_cnt; x.chk_rd = e_chk; x.rd = e_rd; x.force_st = e_force;
    exp_q.push_back(x);
  endtask

  initial begin
    for (int k = 0; k < 4096; k++) mem[k] = 32'd0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 12'd0; bus.cpu_wdata = 32'd0;
    bus.dev_req = 1'b0; bus.dev_we = 1'b0; bus.dev_addr = 12'd0; bus.dev_wdata = 32'd0;

    // reset: both masters requesting writes, nothing may be granted or written
    for (int k = 0; k < 2; k++)
      step(1'b1, 1'b1, 1'b1, 12'h050, 32'hAAAA5555, 1'b1, 1'b1, 12'h060, 32'h5555AAAA,
           1'b0, 1'b0, 1'b0, 12'h050, 32'hAAAA5555, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0);

    // CPU store then load with the device idle
    step(1'b0, 1'b1, 1'b1, 12'h010, DB, 1'b0, 1'b0, 12'h000, 32'd0,
         1'b0, 1'b0, 1'b1, 12'h010, DB, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 12'h010, 32'd0, 1'b0, 1'b0, 12'h000, 32'd0,
         1'b0, 1'b0, 1'b0, 12'h010, 32'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 1'b0, 12'h000, 32'd0,
         1'b0, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 8'd0, 1'b1, DB, 1'b0);

    // device write then back-to-back read with the CPU idle
    step(1'b0, 1'b0, 1'b0, 12'h000, 32'd0, 1'b1, 1'b1, 12'h020, H12,
         1'b1, 1'b0, 1'b1, 12'h020, H12, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0);
    rd_q.push_back(H12);
    step(1'b0, 1'b0, 1'b0, 12'h000, 32'd0, 1'b1, 1'b0, 12'h020, 32'd0,
         1'b1, 1'b0, 1'b0, 12'h020, 32'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 1'b0, 12'h000, 32'd0,
         1'b0, 1'b0, 1'b0, 12'h000, 32'd0, 1'b1, 8'd0, 1'b0, 32'd0, 1'b0);

    // seed 0x030 for the starvation tests
    step(1'b0, 1'b1, 1'b1, 12'h030, CF, 1'b0, 1'b0, 12'h000, 32'd0,
         1'b0, 1'b0, 1'b1, 12'h030, CF, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0);

    // continuous CPU loads vs one device read: forced grant in cycle 9, CPU back in cycle 10
    for (int i = 1; i <= 10; i++) begin
      if (i == 9) rd_q.push_back(CF);
      step(1'b0, 1'b1, 1'b0, 12'h010, 32'd0, (i <= 9), 1'b0, 12'h030, 32'd0,
           (i == 9), (i == 9), 1'b0, ((i == 9) ? 12'h030 : 12'h010), 32'd0,
           (i == 10), ((i == 10) ? 8'd0 : 8'(i - 1)), (i >= 2), ((i == 10) ? CF : DB), (i == 9));
    end

    // device re-requests immediately: a single stall every 9th cycle
    for (int j = 1; j <= 40; j++) begin
      if (j % 9 == 0) rd_q.push_back(CF);
      step(1'b0, 1'b1, 1'b0, 12'h010, 32'd0, 1'b1, 1'b0, 12'h030, 32'd0,
           (j % 9 == 0), (j % 9 == 0), 1'b0, ((j % 9 == 0) ? 12'h030 : 12'h010), 32'd0,
           (j > 1 && (j - 1) % 9 == 0), 8'((j - 1) % 9), 1'b1,
           ((j > 1 && (j - 1) % 9 == 0) ? CF : DB), (j % 9 == 0));
    end

    // dropping dev_req clears the count; then a simultaneous request goes to the CPU
    step(1'b0, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 1'b0, 12'h000, 32'd0,
         1'b0, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 8'd4, 1'b1, DB, 1'b0);
    step(1'b0, 1'b1, 1'b0, 12'h010, 32'd0, 1'b1, 1'b0, 12'h030, 32'd0,
         1'b0, 1'b0, 1'b0, 12'h010, 32'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 12'h010, 32'd0, 1'b0, 1'b0, 12'h000, 32'd0,
         1'b0, 1'b0, 1'b0, 12'h010, 32'd0, 1'b0, 8'd1, 1'b1, DB, 1'b0);
    step(1'b0, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 1'b0, 12'h000, 32'd0,
         1'b0, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 8'd0, 1'b1, DB, 1'b0);

    // reach a forced read, then reset while its read-valid is pending
    for (int i = 1; i <= 9; i++)
      step(1'b0, 1'b1, 1'b0, 12'h010, 32'd0, 1'b1, 1'b0, 12'h030, 32'd0,
           (i == 9), (i == 9), 1'b0, ((i == 9) ? 12'h030 : 12'h010), 32'd0,
           1'b0, 8'(i - 1), (i >= 2), DB, (i == 9));
    for (int k = 0; k < 2; k++)
      step(1'b1, 1'b1, 1'b1, 12'h040, 32'h0BADF00D, 1'b1, 1'b1, 12'h050, 32'h11111111,
           1'b0, 1'b0, 1'b0, 12'h040, 32'h0BADF00D, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0);

    // after reset: nothing was written to 0x040
    step(1'b0, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 1'b0, 12'h000, 32'd0,
         1'b0, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 12'h040, 32'd0, 1'b0, 1'b0, 12'h000, 32'd0,
         1'b0, 1'b0, 1'b0, 12'h040, 32'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 1'b0, 12'h000, 32'd0,
         1'b0, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 8'd0, 1'b1, 32'd0, 1'b0);

    repeat (2) @(negedge clock);
    #1;
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("read_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
